// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole writer of the register file write port.
// Optional starvation guard is enabled by defining STARVE_GUARD_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipe_we,
    input  logic [4:0]             pipe_rd,
    input  logic [31:0]            pipe_wd,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [4:0]             lu_rd,
    input  logic [31:0]            lu_wd,
    output logic                   we3,
    output logic [4:0]             a3,
    output logic [31:0]            wd3,
    output logic [31:0]            pending,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   wb_stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage; the live bit doubles as occupancy for pending
    logic [4:0]       r_rd [DEPTH];
    logic [31:0]      r_wd [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;

    // registered write port
    logic             r_we3;
    logic [4:0]       r_a3;
    logic [31:0]      r_wd3;

    logic             w_pipe_win;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_push_live;
    logic [4:0]       w_head_rd;
    logic [31:0]      w_head_wd;
    logic             w_head_live;
    logic [DEPTH-1:0] w_live_nxt;
    logic [31:0]      w_pending;

    assign w_pipe_win  = pipe_we & (pipe_rd != 5'd0);
    assign w_empty     = (r_count == '0);
    assign w_pop       = ~w_pipe_win & ~w_empty;
    assign lu_ready    = (r_count < CW'(DEPTH));
    // rd==0 completes the handshake but is never stored
    assign w_push      = lu_valid & lu_ready & (lu_rd != 5'd0);
    // a result for the register the pipeline writes now is already stale
    assign w_push_live = ~(w_pipe_win & (lu_rd == pipe_rd));

    assign w_head_rd   = r_rd[r_rp];
    assign w_head_wd   = r_wd[r_rp];
    assign w_head_live = r_live[r_rp];

    // next live bits: squash matching entries, retire head, add new tail
    always_comb begin
        w_live_nxt = r_live;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_pipe_win && (r_rd[i] == pipe_rd)) begin
                w_live_nxt[i] = 1'b0;
            end
        end
        if (w_pop) begin
            w_live_nxt[r_rp] = 1'b0;
        end
        if (w_push) begin
            w_live_nxt[r_wp] = w_push_live;
        end
    end

    // FIFO payload; contents are meaningless without a live bit
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wp] <= lu_rd;
            r_wd[r_wp] <= lu_wd;
        end
    end

    // FIFO control state: pointers, count, live bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_live <= w_live_nxt;
            if (w_push) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // write port arbitration: pipeline first, then FIFO head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else if (w_pipe_win) begin
            r_we3 <= 1'b1;
            r_a3  <= pipe_rd;
            r_wd3 <= pipe_wd;
        end else if (w_pop) begin
            r_we3 <= w_head_live;
            if (w_head_live) begin
                r_a3  <= w_head_rd;
                r_wd3 <= w_head_wd;
            end
        end else begin
            r_we3 <= 1'b0;
        end
    end

    // pending mask from live entries; x0 never reported
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) begin
                w_pending[r_rd[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign we3        = r_we3;
    assign a3         = r_a3;
    assign wd3        = r_wd3;
    assign pending    = w_pending;
    assign fifo_count = r_count;

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_starve;
    logic          r_stall;
    logic [SW-1:0] w_starve_nxt;

    // count consecutive cycles the queued head loses to the pipeline
    always_comb begin
        w_starve_nxt = '0;
        if (!w_empty && w_pipe_win) begin
            if (r_starve == SW'(STARVE_LIMIT)) begin
                w_starve_nxt = r_starve;
            end else begin
                w_starve_nxt = r_starve + SW'(1);
            end
        end
    end

    // starvation counter and registered stall request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            r_stall  <= (w_starve_nxt == SW'(STARVE_LIMIT));
        end
    end

    assign wb_stall = r_stall;
`else
    // no guard: the limit has no effect and the stall is constant 0
    assign wb_stall = (STARVE_LIMIT < 0);
`endif

endmodule
